// File: rtl/rename_pkg.sv
// Shared types and constants for the register-rename retirement path.
package rename_pkg;

    localparam int PREG_W    = 4;
    localparam int AREG_W    = 4;
    localparam int NUM_PREGS = 16;

    typedef logic [PREG_W-1:0] preg_t;

    // One in-flight rename: the register it superseded and the one it claimed.
    typedef struct packed {
        logic  valid;
        logic  done;
        preg_t old_preg;
        preg_t new_preg;
    } rob_entry_t;

endpackage

// File: rtl/rob_ptr.sv
// Circular-buffer pointer: TAG_W index bits plus one wrap bit above them.
module rob_ptr #(
    parameter int TAG_W = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           inc,
    output logic [TAG_W:0] ptr
);

    // Advance by one when enabled; the wrap bit flips naturally on overflow of the index.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + (TAG_W + 1)'(1);
        end
    end

endmodule

// File: rtl/rename_retire_ctrl.sv
// In-order retirement sequencer for the register renamer.
// Tracks each rename allocation in program order, accepts out-of-order
// completion notices, and frees superseded physical registers oldest first,
// one per cycle.
//
// Allocation handshake: an entry transfers on a rising edge where
// alloc_valid && alloc_ready. alloc_ready depends only on buffer state, never
// on alloc_valid. While alloc_ready is low the requester holds alloc_valid and
// its payload stable; the request is simply ignored until space appears.
module rename_retire_ctrl
    import rename_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int PREG_W = rename_pkg::PREG_W,
    parameter int TAG_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alloc_valid,
    input  logic [PREG_W-1:0] alloc_old_preg,
    input  logic [PREG_W-1:0] alloc_new_preg,
    output logic              alloc_ready,
    output logic [TAG_W-1:0]  alloc_tag,
    output logic              rename_ena,
    input  logic              done_valid,
    input  logic [TAG_W-1:0]  done_tag,
    output logic              retire_ena,
    output logic [PREG_W-1:0] retire_preg,
    output logic [TAG_W:0]    occupancy,
    output logic              err_bad_done
);

    // Entry storage, one bit/field per slot.
    logic [DEPTH-1:0]             valid_q;
    logic [DEPTH-1:0]             done_q;
    logic [DEPTH-1:0][PREG_W-1:0] old_q;
    logic [DEPTH-1:0][PREG_W-1:0] new_q;

    logic [TAG_W:0]   head_ptr;
    logic [TAG_W:0]   tail_ptr;
    logic [TAG_W-1:0] head_idx;
    logic [TAG_W-1:0] tail_idx;
    logic             full;
    logic             do_alloc;
    logic             do_retire;
    logic             done_ok;

    // The claimed register is carried for completeness of the entry but the
    // freeing path only ever needs the superseded one.
    logic unused_new_preg;
    assign unused_new_preg = ^new_q;

    assign head_idx = head_ptr[TAG_W-1:0];
    assign tail_idx = tail_ptr[TAG_W-1:0];

    // Full when the indices coincide but the pointers are a lap apart.
    assign full = (head_idx == tail_idx) && (head_ptr[TAG_W] != tail_ptr[TAG_W]);

    assign alloc_ready = !full;
    assign rename_ena  = alloc_ready;
    assign alloc_tag   = tail_idx;
    assign occupancy   = tail_ptr - head_ptr;

    assign do_alloc  = alloc_valid && alloc_ready;
    assign do_retire = valid_q[head_idx] && done_q[head_idx];
    // A head entry that is about to retire is already done, so a completion
    // naming it falls through to the bad-done path.
    assign done_ok   = done_valid && valid_q[done_tag] && !done_q[done_tag];

    rob_ptr #(.TAG_W(TAG_W)) u_head (
        .clk (clk),
        .rst (rst),
        .inc (do_retire),
        .ptr (head_ptr)
    );

    rob_ptr #(.TAG_W(TAG_W)) u_tail (
        .clk (clk),
        .rst (rst),
        .inc (do_alloc),
        .ptr (tail_ptr)
    );

    // Entry bookkeeping: mark completions, clear the retiring head, fill the tail.
    // The three slots touched in one cycle never coincide: the tail slot is
    // invalid whenever an allocation happens, and the retiring head is already done.
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= '0;
            done_q  <= '0;
            old_q   <= '0;
            new_q   <= '0;
        end else begin
            if (done_ok) begin
                done_q[done_tag] <= 1'b1;
            end
            if (do_retire) begin
                valid_q[head_idx] <= 1'b0;
                done_q[head_idx]  <= 1'b0;
            end
            if (do_alloc) begin
                valid_q[tail_idx] <= 1'b1;
                done_q[tail_idx]  <= 1'b0;
                old_q[tail_idx]   <= alloc_old_preg;
                new_q[tail_idx]   <= alloc_new_preg;
            end
        end
    end

    // Registered retire port toward the renamer; the register number holds between pulses.
    always_ff @(posedge clk) begin
        if (!rst) begin
            retire_ena  <= 1'b0;
            retire_preg <= '0;
        end else begin
            retire_ena <= do_retire;
            if (do_retire) begin
                retire_preg <= old_q[head_idx];
            end
        end
    end

    // Sticky flag for completions naming an empty or already-completed slot.
    always_ff @(posedge clk) begin
        if (!rst) begin
            err_bad_done <= 1'b0;
        end else if (done_valid && !done_ok) begin
            err_bad_done <= 1'b1;
        end
    end

endmodule

// File: tb/tb_rename_retire_ctrl.sv
// Bench for rename_retire_ctrl: a program-order queue model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_rename_retire_ctrl;

    localparam int DEPTH  = 8;
    localparam int PREG_W = 4;
    localparam int TAG_W  = 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic              alloc_valid = 1'b0;
    logic [PREG_W-1:0] alloc_old_preg = '0;
    logic [PREG_W-1:0] alloc_new_preg = '0;
    logic              alloc_ready;
    logic [TAG_W-1:0]  alloc_tag;
    logic              rename_ena;
    logic              done_valid = 1'b0;
    logic [TAG_W-1:0]  done_tag = '0;
    logic              retire_ena;
    logic [PREG_W-1:0] retire_preg;
    logic [TAG_W:0]    occupancy;
    logic              err_bad_done;

    rename_retire_ctrl #(.DEPTH(DEPTH), .PREG_W(PREG_W), .TAG_W(TAG_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .alloc_valid    (alloc_valid),
        .alloc_old_preg (alloc_old_preg),
        .alloc_new_preg (alloc_new_preg),
        .alloc_ready    (alloc_ready),
        .alloc_tag      (alloc_tag),
        .rename_ena     (rename_ena),
        .done_valid     (done_valid),
        .done_tag       (done_tag),
        .retire_ena     (retire_ena),
        .retire_preg    (retire_preg),
        .occupancy      (occupancy),
        .err_bad_done   (err_bad_done)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // In-flight renames kept in program order; the front is the oldest.
    typedef struct {
        int              tag;
        logic [PREG_W-1:0] old;
        bit              done;
    } ent_t;

    ent_t              mq[$];
    int                m_tail = 0;      // allocation count modulo 2*DEPTH
    bit                m_ret  = 1'b0;
    logic [PREG_W-1:0] m_preg = '0;
    bit                m_err  = 1'b0;
    logic [PREG_W-1:0] exp_q[$];        // every register the model has freed, in order
    logic [PREG_W-1:0] got_q[$];        // every register the DUT has freed, in order

    always @(posedge clk) begin
        bit   ret;
        bit   rdy;
        bit   found;
        ent_t e;
        if (!rst) begin
            mq.delete();
            m_tail = 0;
            m_ret  = 1'b0;
            m_preg = '0;
            m_err  = 1'b0;
        end else begin
            ret = (mq.size() > 0) && mq[0].done;
            rdy = mq.size() < DEPTH;
            if (done_valid) begin
                found = 1'b0;
                foreach (mq[i]) begin
                    if (mq[i].tag == int'(done_tag) && !mq[i].done && !found) begin
                        mq[i].done = 1'b1;
                        found = 1'b1;
                    end
                end
                if (!found) m_err = 1'b1;
            end
            if (ret) begin
                m_ret  = 1'b1;
                m_preg = mq[0].old;
                exp_q.push_back(mq[0].old);
                void'(mq.pop_front());
            end else begin
                m_ret = 1'b0;
            end
            if (alloc_valid && rdy) begin
                e.tag  = m_tail % DEPTH;
                e.old  = alloc_old_preg;
                e.done = 1'b0;
                mq.push_back(e);
                m_tail = (m_tail + 1) % (2 * DEPTH);
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            chk("alloc_ready",  int'(alloc_ready),  int'(mq.size() < DEPTH));
            chk("rename_ena",   int'(rename_ena),   int'(mq.size() < DEPTH));
            chk("alloc_tag",    int'(alloc_tag),    m_tail % DEPTH);
            chk("occupancy",    int'(occupancy),    mq.size());
            chk("retire_ena",   int'(retire_ena),   int'(m_ret));
            chk("retire_preg",  int'(retire_preg),  int'(m_preg));
            chk("err_bad_done", int'(err_bad_done), int'(m_err));
            if (retire_ena) got_q.push_back(retire_preg);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc(input bit av, input int o, input int n, input bit dv, input int dt);
        alloc_valid    = av;
        alloc_old_preg = PREG_W'(o);
        alloc_new_preg = PREG_W'(n);
        done_valid     = dv;
        done_tag       = TAG_W'(dt);
        @(posedge clk);
        #1;
        alloc_valid = 1'b0;
        done_valid  = 1'b0;
    endtask

    task automatic alloc(input int o, input int n);
        cyc(1'b1, o, n, 1'b0, 0);
    endtask

    task automatic done(input int t);
        cyc(1'b0, 0, 0, 1'b1, t);
    endtask

    task automatic idle();
        cyc(1'b0, 0, 0, 1'b0, 0);
    endtask

    task automatic reset_cycle();
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        @(posedge clk);
        #1;
        reset_cycle();
        chk_en = 1'b1;
        chk("rst_occupancy",   int'(occupancy),    0);
        chk("rst_alloc_ready", int'(alloc_ready),  1);
        chk("rst_retire_ena",  int'(retire_ena),   0);
        chk("rst_retire_preg", int'(retire_preg),  0);
        chk("rst_err",         int'(err_bad_done), 0);

        // Out-of-order completion, in-order retire.
        alloc(1, 8);
        alloc(2, 9);
        alloc(3, 10);
        chk("t1_occ3", int'(occupancy), 3);
        done(2);
        done(1);
        done(0);
        chk("t1_no_same_cycle_retire", int'(retire_ena), 0);
        idle();
        chk("t1_ret0_ena",  int'(retire_ena), 1);
        chk("t1_ret0_preg", int'(retire_preg), 1);
        idle();
        chk("t1_ret1_preg", int'(retire_preg), 2);
        idle();
        chk("t1_ret2_preg", int'(retire_preg), 3);
        idle();
        chk("t1_quiet", int'(retire_ena), 0);
        chk("t1_empty", int'(occupancy), 0);
        chk("t1_order_len", got_q.size(), 3);
        if (got_q.size() == 3) begin
            chk("t1_order0", int'(got_q[0]), 1);
            chk("t1_order1", int'(got_q[1]), 2);
            chk("t1_order2", int'(got_q[2]), 3);
        end

        // Fill to capacity, then a refused request.
        reset_cycle();
        for (int i = 0; i < DEPTH; i++) alloc(i + 5, i + 8);
        chk("t2_ready0",  int'(alloc_ready), 0);
        chk("t2_ena0",    int'(rename_ena), 0);
        chk("t2_occ8",    int'(occupancy), 8);
        chk("t2_tag0",    int'(alloc_tag), 0);
        alloc(15, 15);
        chk("t2_ignored_occ", int'(occupancy), 8);
        chk("t2_ignored_tag", int'(alloc_tag), 0);

        // Free the oldest from full; no same-cycle bypass.
        done(0);
        chk("t3_pending_ready", int'(alloc_ready), 0);
        chk("t3_pending_ret",   int'(retire_ena), 0);
        idle();
        chk("t3_ret_ena",  int'(retire_ena), 1);
        chk("t3_ret_preg", int'(retire_preg), 5);
        chk("t3_ready1",   int'(alloc_ready), 1);
        chk("t3_tag0",     int'(alloc_tag), 0);
        alloc(14, 3);
        chk("t3_wrapped_full", int'(occupancy), 8);
        chk("t3_tag1",         int'(alloc_tag), 1);
        chk("t3_ready_again",  int'(alloc_ready), 0);

        // Allocate and retire in the same cycle.
        reset_cycle();
        for (int i = 0; i < 4; i++) alloc(i + 1, i + 9);
        done(0);
        chk("t4_occ_before", int'(occupancy), 4);
        chk("t4_tag_before", int'(alloc_tag), 4);
        alloc(6, 7);
        chk("t4_occ_after",  int'(occupancy), 4);
        chk("t4_tag_after",  int'(alloc_tag), 5);
        chk("t4_ret_ena",    int'(retire_ena), 1);
        chk("t4_ret_preg",   int'(retire_preg), 1);

        // Bad completions.
        reset_cycle();
        alloc(1, 8);
        alloc(2, 9);
        alloc(3, 10);
        chk("t5_err_clean", int'(err_bad_done), 0);
        done(5);
        chk("t5_err_invalid", int'(err_bad_done), 1);
        done(1);
        done(1);
        chk("t5_err_sticky", int'(err_bad_done), 1);
        chk("t5_occ",        int'(occupancy), 3);
        chk("t5_no_ret",     int'(retire_ena), 0);
        done(0);
        idle();
        chk("t5_ret_a", int'(retire_preg), 1);
        idle();
        chk("t5_ret_b", int'(retire_preg), 2);
        idle();
        chk("t5_stop",  int'(retire_ena), 0);
        chk("t5_occ1",  int'(occupancy), 1);

        // Reset discards completed-but-blocked entries.
        reset_cycle();
        for (int i = 0; i < 4; i++) alloc(i + 7, i + 1);
        done(1);
        done(2);
        done(3);
        chk("t6_blocked", int'(retire_ena), 0);
        chk("t6_occ4",    int'(occupancy), 4);
        reset_cycle();
        chk("t6_ret_off", int'(retire_ena), 0);
        chk("t6_occ0",    int'(occupancy), 0);
        chk("t6_tag0",    int'(alloc_tag), 0);
        idle();
        idle();
        idle();
        chk("t6_still_off", int'(retire_ena), 0);
        done(0);
        chk("t6_stale_done", int'(err_bad_done), 1);

        idle();
        chk("retire_count", got_q.size(), exp_q.size());
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Watchdog.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timeout");
    end

endmodule

// File: doc/rename_retire_ctrl.md
Name: rename_retire_ctrl

Overview:
- In-order retirement sequencer for the register renamer.
- Records each rename allocation in program order: the superseded physical register and the newly claimed one.
- Accepts out-of-order completion notices and drives the renamer's retire port, one physical register per cycle, oldest first.
- Back-pressures rename by driving the renamer's enable when its tracking buffer is full.

Parameters:
- DEPTH, 8, number of in-flight tracking entries; must be a power of two, 2..16.
- PREG_W, 4, width of a physical register index.
- TAG_W, $clog2(DEPTH), width of the entry tag returned to the issue side.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- alloc_valid  input  1  rename of a destination register requested this cycle.
- alloc_old_preg  input  PREG_W  physical register previously mapped to the destination (renamer wbsout[7:4]).
- alloc_new_preg  input  PREG_W  physical register newly claimed (renamer wbsout[3:0]).
- alloc_ready  output  1  entry available; combinational, equals !full.
- alloc_tag  output  TAG_W  tag assigned to an accepted allocation; combinational, equals the tail index.
- rename_ena  output  1  drives the renamer's ena; equals alloc_ready.
- done_valid  input  1  an instruction has written back.
- done_tag  input  TAG_W  tag of the completed instruction.
- retire_ena  output  1  registered; drives the renamer's retire_ena_in.
- retire_preg  output  PREG_W  registered; drives the renamer's retirein (the superseded register being freed).
- occupancy  output  TAG_W+1  number of valid entries.
- err_bad_done  output  1  sticky; set when done_tag names an invalid entry or an entry already done.

Behaviour:
- Storage is a circular buffer of DEPTH entries. Each entry holds valid, done, old_preg and new_preg.
- head and tail are TAG_W+1 bits wide; the MSB is the wrap bit.
  - empty = (head == tail).
  - full = indices equal and wrap bits differ.
- Reset (rst == 0 at a clock edge):
  - head = tail = 0; all valid and done bits = 0.
  - retire_ena = 0, retire_preg = 0, err_bad_done = 0.
  - occupancy = 0, alloc_ready = 1.
  - Reset asserted mid-operation discards every in-flight entry; no retire is issued for them.
- Allocate: when alloc_valid && alloc_ready:
  - write {valid=1, done=0, old, new} at tail[TAG_W-1:0];
  - tail increments and wraps naturally through the wrap bit.
  - alloc_valid while full is ignored and leaves state unchanged. The issue side must hold its request.
- Complete: when done_valid and entry[done_tag] is valid and not done, set done = 1. Otherwise set err_bad_done, with no other effect.
- Retire (state machine IDLE/RETIRE is implicit; one retire per cycle):
  - Condition: at an edge where the head entry is valid && done.
  - Register retire_ena = 1 and retire_preg = head old_preg.
  - Clear the entry's valid and done bits; head increments.
  - Otherwise retire_ena = 0 and retire_preg holds its last value.
- Latency:
  - done_valid in cycle N sets done at edge N.
  - The earliest retire_ena is asserted in cycle N+1.
  - A completion cannot retire in the same cycle it arrives.
- Simultaneous events:
  - Allocate and retire in the same cycle: both take effect; occupancy is unchanged.
  - When full, alloc_ready stays 0 in the cycle a retire frees an entry (no same-cycle bypass). Allocation resumes the following cycle.
  - done_valid naming the head while the head is already retiring is flagged as a bad done, because the entry is already done.
- occupancy = tail - head, computed in TAG_W+1 bits.
- No flush or recovery in this revision.

Decomposition:
- Shared package rename_pkg holds:
  - localparams PREG_W=4, AREG_W=4, NUM_PREGS=16;
  - typedef preg_t (logic [PREG_W-1:0]);
  - packed struct rob_entry_t {valid, done, old_preg, new_preg}.
- One sub-module, rob_ptr, is natural: a wrapping pointer with wrap bit, increment enable and synchronous active-low reset. It is instantiated twice, for head and tail.
- Storage and retire logic stay in rename_retire_ctrl.

Test Plan:
- Reset, then allocate old/new pairs (1,8), (2,9), (3,10), then done tags 2,1,0 on consecutive cycles. Required: retires of preg 1, 2, 3 in that order. The first retire comes one cycle after tag 0 completes; occupancy ends at 0.
- Allocate 8 entries with no completions. Required: alloc_ready = 0, rename_ena = 0, occupancy = 8. A 9th alloc_valid is ignored and the tail does not move.
- From full, complete tag 0. Required:
  - retire_ena pulses with preg = entry0.old;
  - alloc_ready is still 0 that cycle and 1 the next;
  - a new allocation gets tag 0 with its wrap bit toggled.
- Allocate and retire in the same cycle at occupancy 4. Required: occupancy stays 4, both alloc_tag and head advance by 1.
- Issue done_tag = 5 while only tags 0..2 are valid, then done tag 1 twice. Required: err_bad_done set after the first bad done and remaining 1; entry states unchanged.
- Drive rst = 0 for one cycle with 3 completed entries pending. Required: retire_ena = 0 the next cycle, occupancy = 0, no retire of any pending preg, alloc_tag = 0.
